// File: rtl/tlb_pkg.sv
// Shared constants and line layout for the associative TLB.
// Default widths mirror the top-level parameter defaults.
package tlb_pkg;

  localparam int PTE_PRESENT_BIT = 0;
  localparam int DEF_ENTRIES     = 16;
  localparam int DEF_PGNO_W      = 52;
  localparam int DEF_ENTRY_W     = 64;
  localparam int DEF_CNT_W       = 32;

  typedef struct packed {
    logic                   valid;
    logic [DEF_PGNO_W-1:0]  pgno;
    logic [DEF_ENTRY_W-1:0] entry;
  } tlb_line_t;

endpackage

// File: rtl/tlb_victim_sel.sv
// Slot selection for fills: lowest free index plus a round-robin
// replacement pointer that only moves when a full TLB evicts.
module tlb_victim_sel #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRIES-1:0] valid_i,
  input  logic               advance_i,
  output logic [IDX_W-1:0]   free_idx_o,
  output logic               any_free_o,
  output logic [IDX_W-1:0]   victim_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan high to low so the lowest free slot is the last one assigned.
  always_comb begin
    free_idx_o = '0;
    any_free_o = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_idx_o = IDX_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

  // ENTRIES is a power of two, so natural wrap gives mod ENTRIES.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = ptr_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign victim_o = ptr_q;

endmodule

// File: rtl/tlb_assoc.sv
// Fully associative TLB with registered lookup, fill allocation,
// single-page invalidate, flush and saturating hit/miss counters.
module tlb_assoc
  import tlb_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int PGNO_W  = DEF_PGNO_W,
  parameter int ENTRY_W = DEF_ENTRY_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup,
  input  logic [PGNO_W-1:0]  pageno,
  output logic               hit,
  output logic               miss,
  output logic [ENTRY_W-1:0] data,
  input  logic               write,
  input  logic [PGNO_W-1:0]  wrpageno,
  input  logic [ENTRY_W-1:0] tableentry,
  input  logic               inval,
  input  logic [PGNO_W-1:0]  invpageno,
  input  logic               flush,
  output logic               full,
  output logic [CNT_W-1:0]   hitcount,
  output logic [CNT_W-1:0]   misscount
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][PGNO_W-1:0]  pgno_q;
  logic [ENTRIES-1:0][ENTRY_W-1:0] entry_q;

  logic [ENTRIES-1:0] lk_match, wr_match, iv_match, alloc_sel, wr_sel;
  logic [ENTRY_W-1:0] lk_data;
  logic               lk_any, wr_hit, wr_present, advance, any_free;
  logic [IDX_W-1:0]   free_idx, victim_idx;

  logic               hit_q, miss_q, full_q;
  logic [ENTRY_W-1:0] data_q;
  logic [CNT_W-1:0]   hitcnt_q, misscnt_q;

  // All comparators look at pre-update contents (read-before-write).
  always_comb begin
    lk_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match[i] = valid_q[i] && (pgno_q[i] == pageno) && entry_q[i][PTE_PRESENT_BIT];
      wr_match[i] = valid_q[i] && (pgno_q[i] == wrpageno);
      iv_match[i] = valid_q[i] && (pgno_q[i] == invpageno);
      if (lk_match[i]) lk_data = lk_data | entry_q[i];
    end
  end

  assign lk_any     = |lk_match;
  assign wr_hit     = |wr_match;
  assign wr_present = tableentry[PTE_PRESENT_BIT];

  tlb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_q),
    .advance_i  (advance),
    .free_idx_o (free_idx),
    .any_free_o (any_free),
    .victim_o   (victim_idx)
  );

  always_comb begin
    alloc_sel = '0;
    alloc_sel[any_free ? free_idx : victim_idx] = 1'b1;
  end

  // Inval is applied before the write so a same-page write re-validates.
  always_comb begin
    valid_d = valid_q;
    wr_sel  = '0;
    advance = 1'b0;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (inval) valid_d = valid_d & ~iv_match;
      if (write) begin
        if (!wr_present) begin
          valid_d = valid_d & ~wr_match;
        end else begin
          wr_sel  = wr_hit ? wr_match : alloc_sel;
          valid_d = valid_d | wr_sel;
          advance = !wr_hit && !any_free;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      full_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      data_q    <= '0;
      hitcnt_q  <= '0;
      misscnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      full_q  <= &valid_d;
      hit_q   <= lookup && lk_any;
      miss_q  <= lookup && !lk_any;
      data_q  <= lookup ? lk_data : '0;
      if (lookup && lk_any && (hitcnt_q != '1))   hitcnt_q  <= hitcnt_q + CNT_W'(1);
      if (lookup && !lk_any && (misscnt_q != '1)) misscnt_q <= misscnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (wr_sel[i]) begin
        pgno_q[i]  <= wrpageno;
        entry_q[i] <= tableentry;
      end
    end
  end

  assign hit       = hit_q;
  assign miss      = miss_q;
  assign data      = data_q;
  assign full      = full_q;
  assign hitcount  = hitcnt_q;
  assign misscount = misscnt_q;

endmodule

// File: tb/tb_tlb_assoc.sv
// Self-checking bench for tlb_assoc: directed scenarios plus randomized
// traffic compared against a slot-array reference model.
module tb_tlb_assoc;
  import tlb_pkg::*;

  localparam int ENTRIES = 16;
  localparam int PGNO_W  = 52;
  localparam int ENTRY_W = 64;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               reset, lookup, write, inval, flush;
  logic [PGNO_W-1:0]  pageno, wrpageno, invpageno;
  logic [ENTRY_W-1:0] tableentry;
  logic               hit, miss, full;
  logic [ENTRY_W-1:0] data;
  logic [CNT_W-1:0]   hitcount, misscount;

  int checks = 0;
  int errors = 0;

  tlb_line_t          m [ENTRIES];
  int                 vic;
  logic               exp_hit, exp_miss, exp_full;
  logic [ENTRY_W-1:0] exp_data;
  logic [CNT_W-1:0]   exp_hc, exp_mc;

  tlb_assoc #(
    .ENTRIES (ENTRIES),
    .PGNO_W  (PGNO_W),
    .ENTRY_W (ENTRY_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lookup     (lookup),
    .pageno     (pageno),
    .hit        (hit),
    .miss       (miss),
    .data       (data),
    .write      (write),
    .wrpageno   (wrpageno),
    .tableentry (tableentry),
    .inval      (inval),
    .invpageno  (invpageno),
    .flush      (flush),
    .full       (full),
    .hitcount   (hitcount),
    .misscount  (misscount)
  );

  always #5 clk = ~clk;

  // Reference: slot array updated from the behavioural rules each edge.
  task automatic model_step();
    int   ws;
    bit   found, replace, all_v;
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) m[i].valid = 1'b0;
      vic = 0; exp_hit = 0; exp_miss = 0; exp_data = '0;
      exp_hc = '0; exp_mc = '0; exp_full = 0;
    end else begin
      exp_hit = 0; exp_miss = 0; exp_data = '0;
      if (lookup) begin
        exp_miss = 1;
        for (int i = 0; i < ENTRIES; i++)
          if (m[i].valid && m[i].pgno == pageno && m[i].entry[0]) begin
            exp_hit = 1; exp_miss = 0; exp_data = m[i].entry;
          end
        if (exp_hit && exp_hc != 4'hF) exp_hc = exp_hc + 4'd1;
        if (exp_miss && exp_mc != 4'hF) exp_mc = exp_mc + 4'd1;
      end
      ws = -1;
      for (int i = 0; i < ENTRIES; i++)
        if (m[i].valid && m[i].pgno == wrpageno) ws = i;
      found = (ws >= 0);
      if (!found)
        for (int i = 0; i < ENTRIES; i++)
          if (ws < 0 && !m[i].valid) ws = i;
      replace = (ws < 0);
      if (replace) ws = vic;
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) m[i].valid = 1'b0;
      end else begin
        if (inval)
          for (int i = 0; i < ENTRIES; i++)
            if (m[i].valid && m[i].pgno == invpageno) m[i].valid = 1'b0;
        if (write) begin
          if (tableentry[0]) begin
            m[ws].valid = 1'b1; m[ws].pgno = wrpageno; m[ws].entry = tableentry;
            if (replace) vic = (vic + 1) % ENTRIES;
          end else if (found) begin
            m[ws].valid = 1'b0;
          end
        end
      end
      all_v = 1;
      for (int i = 0; i < ENTRIES; i++) if (!m[i].valid) all_v = 0;
      exp_full = all_v;
    end
  endtask

  task automatic idle_inputs();
    reset = 0; lookup = 0; write = 0; inval = 0; flush = 0;
    pageno = '0; wrpageno = '0; invpageno = '0; tableentry = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; step(); reset = 0;
  endtask

  task automatic do_write(input logic [PGNO_W-1:0] p, input logic [ENTRY_W-1:0] e);
    idle_inputs(); write = 1; wrpageno = p; tableentry = e; step(); idle_inputs();
  endtask

  task automatic do_lookup(input logic [PGNO_W-1:0] p);
    idle_inputs(); lookup = 1; pageno = p; step(); idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({hit, miss, data, full, hitcount, misscount} !== '0) begin
      errors++;
      $display("FAIL reset_state: hit=%0b miss=%0b data=%h full=%0b hc=%0d mc=%0d, want all 0",
               hit, miss, data, full, hitcount, misscount);
    end
  endtask

  task automatic test_basic_lookup();
    do_reset();
    do_lookup(52'h5);
    checks++;
    if ({hit, miss, data, misscount} !== {1'b0, 1'b1, 64'h0, 4'd1}) begin
      errors++;
      $display("FAIL first_miss: hit=%0b miss=%0b data=%h mc=%0d, want 0 1 0 1", hit, miss, data, misscount);
    end
    idle_inputs(); step();
    checks++;
    if ({hit, miss, data} !== '0) begin
      errors++;
      $display("FAIL idle_no_result: hit=%0b miss=%0b data=%h, want 0 0 0", hit, miss, data);
    end
    do_write(52'h5, 64'h0000_0000_0000_0A01);
    do_lookup(52'h5);
    checks++;
    if ({hit, miss, data, hitcount} !== {1'b1, 1'b0, 64'h0A01, 4'd1}) begin
      errors++;
      $display("FAIL fill_hit: hit=%0b miss=%0b data=%h hc=%0d, want 1 0 0a01 1", hit, miss, data, hitcount);
    end
  endtask

  task automatic test_fill_replace();
    do_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      do_write(52'(100 + i), 64'(32'h1000 + (i << 4) + 1));
      checks++;
      if (full !== (i == ENTRIES - 1)) begin
        errors++;
        $display("FAIL full_flag fill %0d: full=%0b want %0b", i, full, (i == ENTRIES - 1));
      end
    end
    do_write(52'd200, 64'hC801);
    do_write(52'd201, 64'hC901);
    do_lookup(52'd100);
    checks++;
    if (miss !== 1'b1) begin
      errors++; $display("FAIL evict_slot0: miss=%0b want 1", miss);
    end
    do_lookup(52'd101);
    checks++;
    if (miss !== 1'b1) begin
      errors++; $display("FAIL evict_slot1: miss=%0b want 1", miss);
    end
    do_lookup(52'd102);
    checks++;
    if ({hit, data} !== {1'b1, 64'h1021}) begin
      errors++; $display("FAIL keep_slot2: hit=%0b data=%h want 1 1021", hit, data);
    end
    do_lookup(52'd201);
    checks++;
    if ({hit, data, full} !== {1'b1, 64'hC901, 1'b1}) begin
      errors++; $display("FAIL replaced_hit: hit=%0b data=%h full=%0b want 1 c901 1", hit, data, full);
    end
  endtask

  task automatic test_same_cycle_rw();
    do_reset();
    idle_inputs(); lookup = 1; pageno = 52'h5; write = 1; wrpageno = 52'h5; tableentry = 64'hBEEF;
    step(); idle_inputs();
    checks++;
    if ({hit, miss} !== 2'b01) begin
      errors++; $display("FAIL rbw_old_contents: hit=%0b miss=%0b want 0 1", hit, miss);
    end
    do_lookup(52'h5);
    checks++;
    if ({hit, data} !== {1'b1, 64'hBEEF}) begin
      errors++; $display("FAIL rbw_next_cycle: hit=%0b data=%h want 1 beef", hit, data);
    end
  endtask

  task automatic test_inval_flush();
    do_reset();
    do_write(52'h5, 64'h0501);
    idle_inputs(); inval = 1; invpageno = 52'h5; write = 1; wrpageno = 52'h7; tableentry = 64'h0701;
    step();
    do_lookup(52'h5);
    checks++;
    if (miss !== 1'b1) begin
      errors++; $display("FAIL inval_diff_page: miss=%0b want 1", miss);
    end
    do_lookup(52'h7);
    checks++;
    if ({hit, data} !== {1'b1, 64'h0701}) begin
      errors++; $display("FAIL write_diff_page: hit=%0b data=%h want 1 0701", hit, data);
    end
    idle_inputs(); inval = 1; invpageno = 52'h7; write = 1; wrpageno = 52'h7; tableentry = 64'h0703;
    step();
    do_lookup(52'h7);
    checks++;
    if ({hit, data} !== {1'b1, 64'h0703}) begin
      errors++; $display("FAIL inval_write_same: hit=%0b data=%h want 1 0703", hit, data);
    end
    do_write(52'h7, 64'h0700);
    do_lookup(52'h7);
    checks++;
    if (miss !== 1'b1) begin
      errors++; $display("FAIL nonpresent_write: miss=%0b want 1", miss);
    end
    do_write(52'h8, 64'h0801);
    idle_inputs(); flush = 1; write = 1; wrpageno = 52'h9; tableentry = 64'h0901;
    step();
    do_lookup(52'h8);
    checks++;
    if (miss !== 1'b1) begin
      errors++; $display("FAIL flush_old: miss=%0b want 1", miss);
    end
    do_lookup(52'h9);
    checks++;
    if (miss !== 1'b1) begin
      errors++; $display("FAIL flush_beats_write: miss=%0b want 1", miss);
    end
  endtask

  task automatic test_saturate_midreset();
    do_reset();
    do_write(52'h3, 64'h0301);
    for (int i = 0; i < 20; i++) do_lookup(52'h3);
    checks++;
    if ({hit, hitcount} !== {1'b1, 4'hF}) begin
      errors++; $display("FAIL hit_saturate: hit=%0b hc=%h want 1 f", hit, hitcount);
    end
    for (int i = 0; i < 18; i++) do_lookup(52'h4);
    checks++;
    if ({misscount, hitcount} !== {4'hF, 4'hF}) begin
      errors++; $display("FAIL miss_saturate: mc=%h hc=%h want f f", misscount, hitcount);
    end
    idle_inputs(); reset = 1; lookup = 1; pageno = 52'h3;
    step(); idle_inputs();
    checks++;
    if ({hit, miss, data, full, hitcount, misscount} !== '0) begin
      errors++;
      $display("FAIL midstream_reset: hit=%0b miss=%0b data=%h full=%0b hc=%0d mc=%0d, want all 0",
               hit, miss, data, full, hitcount, misscount);
    end
    do_lookup(52'h3);
    checks++;
    if ({hit, miss} !== 2'b01) begin
      errors++; $display("FAIL post_reset_empty: hit=%0b miss=%0b want 0 1", hit, miss);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      reset      = ($urandom_range(0, 199) == 0);
      lookup     = ($urandom_range(0, 9) < 6);
      write      = ($urandom_range(0, 9) < 4);
      inval      = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 49) == 0);
      pageno     = 52'($urandom_range(0, 23));
      wrpageno   = 52'($urandom_range(0, 23));
      invpageno  = 52'($urandom_range(0, 23));
      tableentry = {$urandom, $urandom};
      tableentry[0] = ($urandom_range(0, 9) < 8);
      step();
      checks++;
      if ({hit, miss, data, full, hitcount, misscount} !==
          {exp_hit, exp_miss, exp_data, exp_full, exp_hc, exp_mc}) begin
        errors++;
        $display("FAIL random cycle %0d: got hit=%0b miss=%0b data=%h full=%0b hc=%0d mc=%0d want %0b %0b %h %0b %0d %0d",
                 n, hit, miss, data, full, hitcount, misscount,
                 exp_hit, exp_miss, exp_data, exp_full, exp_hc, exp_mc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_lookup();
    test_fill_replace();
    test_same_cycle_rw();
    test_inval_flush();
    test_saturate_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
